// File: rtl/spi_master_regmap_if.sv
// Request/response bus between a host and spi_master_regmap.
//   req_valid/req_ready  accept handshake (accept when both high on clk edge)
//   req_rd/addr/wdata    request fields, captured on accept
//   rsp_valid/rsp_rdata  one-cycle completion pulse and read data
//   busy                 frame or inter-frame gap in progress
// master = host side, slave = SPI master block side.
interface spi_master_regmap_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_rd;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  busy;

  modport master (
    output req_valid, req_rd, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_rd, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/spi_master_regmap.sv
// SPI mode-0 master for register read/write frames {rd, addr, data}.
// Ports:
//   clk, rst  rising-edge clock, synchronous active-high reset
//   bus       request/response handshake (slave modport)
//   sck_o     SPI clock, idle low
//   sdo_o     MOSI, MSB first, changes with SCK falling
//   sdi_i     MISO, sampled with SCK rising (responder is clk-synchronous)
//   cs_n_o    chip select, active low
//
// state | meaning
// IDLE  | ready for a request, cs_n high
// SETUP | cs_n low, MSB on sdo, one half-period before first SCK rise
// SHIFT | SCK toggling, FW rising and FW falling edges
// HOLD  | SCK low after last fall, one half-period before cs_n release
// GAP   | cs_n high for two half-periods before the next frame
module spi_master_regmap #(
  parameter int HALF_DIV   = 5,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_master_regmap_if.slave    bus,
  output logic                  sck_o,
  output logic                  sdo_o,
  input  logic                  sdi_i,
  output logic                  cs_n_o
);
  localparam int FW    = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int DIV_W = $clog2(HALF_DIV);
  localparam int BIT_W = $clog2(FW + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(HALF_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FW - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q;
  logic [BIT_W-1:0]      bit_q;
  logic [FW-1:0]         tx_q;
  logic [FW-1:0]         frame;
  // Only the last DATA_WIDTH samples can reach rsp_rdata, so older ones shift out.
  logic [DATA_WIDTH-1:0] rx_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rd_q;
  logic                  rsp_valid_q;
  logic                  accept;
  logic                  tick;
  logic                  last_fall;

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;

  assign accept    = bus.req_valid && bus.req_ready;
  assign tick      = (div_q == '0);
  // sck_o high at a tick means this tick drives a falling edge.
  assign last_fall = sck_o && (bit_q == LAST_BIT);
  assign frame     = {bus.req_rd, bus.req_addr,
                      bus.req_rd ? {DATA_WIDTH{1'b0}} : bus.req_wdata};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)                     state_d = SETUP;
      SETUP:   if (tick)                       state_d = SHIFT;
      SHIFT:   if (tick && last_fall)          state_d = HOLD;
      HOLD:    if (tick)                       state_d = GAP;
      GAP:     if (tick && bit_q == BIT_W'(1)) state_d = IDLE;
      default:                                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rdata_q     <= '0;
      rd_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      cs_n_o      <= 1'b1;
      sck_o       <= 1'b0;
      sdo_o       <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (accept) begin
        div_q  <= DIV_LOAD;
        bit_q  <= '0;
        rx_q   <= '0;
        rd_q   <= bus.req_rd;
        sdo_o  <= frame[FW-1];
        tx_q   <= frame << 1;
        cs_n_o <= 1'b0;
        sck_o  <= 1'b0;
      end else if (state_q != IDLE) begin
        div_q <= tick ? DIV_LOAD : div_q - 1'b1;
        if (tick) begin
          case (state_q)
            SETUP: begin
              sck_o <= 1'b1;
              rx_q  <= {rx_q[DATA_WIDTH-2:0], sdi_i};
            end
            SHIFT: begin
              if (sck_o) begin
                sck_o <= 1'b0;
                bit_q <= bit_q + 1'b1;
                // After the last fall sdo keeps the final bit through HOLD.
                if (!last_fall) begin
                  sdo_o <= tx_q[FW-1];
                  tx_q  <= tx_q << 1;
                end
              end else begin
                sck_o <= 1'b1;
                rx_q  <= {rx_q[DATA_WIDTH-2:0], sdi_i};
              end
            end
            HOLD: begin
              cs_n_o      <= 1'b1;
              sdo_o       <= 1'b0;
              rsp_valid_q <= 1'b1;
              rdata_q     <= rd_q ? rx_q : '0;
              bit_q       <= '0;  // reused to count the two GAP half-periods
            end
            GAP:     bit_q <= BIT_W'(1);
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_master_regmap.sv
module tb_spi_master_regmap;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_regmap_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) bus0 ();
  spi_master_regmap_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) bus1 ();

  logic sck0, sdo0, cs0;
  logic sdi0 = 1'b0;
  logic sck1, sdo1, cs1;

  spi_master_regmap #(.HALF_DIV(5), .ADDR_WIDTH(7), .DATA_WIDTH(8)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .sck_o(sck0), .sdo_o(sdo0), .sdi_i(sdi0), .cs_n_o(cs0));

  spi_master_regmap #(.HALF_DIV(2), .ADDR_WIDTH(7), .DATA_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .sck_o(sck1), .sdo_o(sdo1), .sdi_i(1'b0), .cs_n_o(cs1));

  int checks = 0;
  int failures = 0;

  // SPI slave-side observer and responder for dut0
  int rises0 = 0, falls0 = 0, low0 = 0, high0 = 0;
  int last_low0 = 0, last_rises0 = 0, last_gap0 = 0, rsp_cnt0 = 0;
  logic [15:0] mosi0 = '0, last_mosi0 = '0;
  logic prev_sck0 = 1'b0, prev_cs0 = 1'b1;
  logic [7:0] resp_byte = '0;

  always @(negedge clk) begin
    if (bus0.rsp_valid === 1'b1) rsp_cnt0++;
    if (cs0 === 1'b0) begin
      if (prev_cs0) begin
        last_gap0 = high0; low0 = 0; rises0 = 0; falls0 = 0; mosi0 = '0;
      end
      low0++;
      if (!prev_sck0 && sck0) begin mosi0 = {mosi0[14:0], sdo0}; rises0++; end
      if (prev_sck0 && !sck0) begin
        falls0++;
        if (falls0 >= 8 && falls0 <= 15) sdi0 = resp_byte[15-falls0];
      end
    end else begin
      if (!prev_cs0) begin
        last_low0 = low0; last_mosi0 = mosi0; last_rises0 = rises0; high0 = 0;
      end
      high0++;
      sdi0 = 1'b0;
    end
    prev_sck0 = sck0;
    prev_cs0  = cs0;
  end

  // Observer for dut1 (HALF_DIV=2), also measures SCK rising-edge period
  int cyc1 = 0, low1 = 0, rises1 = 0, last_rise1 = 0, pmin1 = 0, pmax1 = 0, per1 = 0;
  int last_low1 = 0, last_rises1 = 0, last_pmin1 = 0, last_pmax1 = 0;
  logic [15:0] mosi1 = '0, last_mosi1 = '0;
  logic prev_sck1 = 1'b0, prev_cs1 = 1'b1;

  always @(negedge clk) begin
    cyc1++;
    if (cs1 === 1'b0) begin
      if (prev_cs1) begin low1 = 0; rises1 = 0; mosi1 = '0; pmin1 = 1000; pmax1 = 0; end
      low1++;
      if (!prev_sck1 && sck1) begin
        mosi1 = {mosi1[14:0], sdo1};
        if (rises1 > 0) begin
          per1 = cyc1 - last_rise1;
          if (per1 < pmin1) pmin1 = per1;
          if (per1 > pmax1) pmax1 = per1;
        end
        last_rise1 = cyc1;
        rises1++;
      end
    end else if (!prev_cs1) begin
      last_low1 = low1; last_mosi1 = mosi1; last_rises1 = rises1;
      last_pmin1 = pmin1; last_pmax1 = pmax1;
    end
    prev_sck1 = sck1;
    prev_cs1  = cs1;
  end

  task automatic send0(input logic rd, input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk); #1;
    bus0.req_rd = rd; bus0.req_addr = a; bus0.req_wdata = d; bus0.req_valid = 1'b1;
    while (bus0.req_ready !== 1'b1 && n < 1000) begin @(negedge clk); #1; n++; end
    checks++;
    if (n >= 1000) begin
      failures++;
      $display("FAIL send0_accept_timeout req_ready=%b expected=1", bus0.req_ready);
    end
    @(negedge clk); #1;
    bus0.req_valid = 1'b0;
  endtask

  task automatic wait_rsp0(output logic got, output logic [7:0] data);
    got = 1'b0; data = '0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk); #1;
      if (bus0.rsp_valid === 1'b1) begin got = 1'b1; data = bus0.rsp_rdata; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus0.req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus0.req_ready); end
    checks++;
    if ({cs0, sck0, sdo0} !== 3'b100) begin failures++; $display("FAIL reset_pins got=%b exp=100", {cs0, sck0, sdo0}); end
    checks++;
    if ({bus0.rsp_valid, bus0.busy} !== 2'b00) begin failures++; $display("FAIL reset_valid_busy got=%b exp=00", {bus0.rsp_valid, bus0.busy}); end
    checks++;
    if (bus0.rsp_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", bus0.rsp_rdata); end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({bus0.req_ready, bus1.req_ready, bus0.busy} !== 3'b110) begin
      failures++; $display("FAIL reset_release_ready got=%b exp=110", {bus0.req_ready, bus1.req_ready, bus0.busy});
    end
  endtask

  task automatic test_write();
    logic got; logic [7:0] d; int c0;
    c0 = rsp_cnt0;
    send0(1'b0, 7'h12, 8'hA5);
    wait_rsp0(got, d);
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL write_rsp got=%b exp=1", got); end
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL write_rdata got=%h exp=00", d); end
    checks++; if (last_mosi0 !== 16'h12A5) begin failures++; $display("FAIL write_mosi got=%h exp=12a5", last_mosi0); end
    checks++; if (last_low0 != 165) begin failures++; $display("FAIL write_cs_low got=%0d exp=165", last_low0); end
    checks++; if (last_rises0 != 16) begin failures++; $display("FAIL write_sck_rises got=%0d exp=16", last_rises0); end
    @(negedge clk); #1;
    checks++;
    if ({bus0.rsp_valid, bus0.busy, cs0} !== 3'b011) begin
      failures++; $display("FAIL write_after_pulse got=%b exp=011", {bus0.rsp_valid, bus0.busy, cs0});
    end
    checks++; if (rsp_cnt0 - c0 != 1) begin failures++; $display("FAIL write_rsp_count got=%0d exp=1", rsp_cnt0 - c0); end
    repeat (12) @(negedge clk);
    #1;
    checks++;
    if ({bus0.req_ready, bus0.busy} !== 2'b10) begin
      failures++; $display("FAIL write_back_idle got=%b exp=10", {bus0.req_ready, bus0.busy});
    end
  endtask

  task automatic test_read();
    logic got; logic [7:0] d;
    resp_byte = 8'h3C;
    send0(1'b1, 7'h05, 8'hFF);
    wait_rsp0(got, d);
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL read_rsp got=%b exp=1", got); end
    checks++; if (d !== 8'h3C) begin failures++; $display("FAIL read_rdata got=%h exp=3c", d); end
    checks++; if (last_mosi0 !== 16'h8500) begin failures++; $display("FAIL read_mosi got=%h exp=8500", last_mosi0); end
    checks++; if (last_low0 != 165) begin failures++; $display("FAIL read_cs_low got=%0d exp=165", last_low0); end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus0.rsp_rdata !== 8'h3C || bus0.rsp_valid !== 1'b0) begin
      failures++; $display("FAIL read_rdata_hold got=%h/%b exp=3c/0", bus0.rsp_rdata, bus0.rsp_valid);
    end
    resp_byte = 8'h00;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic got; logic [7:0] d; int c0; int n;
    c0 = rsp_cnt0;
    @(negedge clk); #1;
    bus0.req_rd = 1'b0; bus0.req_addr = 7'h21; bus0.req_wdata = 8'h11; bus0.req_valid = 1'b1;
    n = 0;
    while (bus0.req_ready !== 1'b1 && n < 1000) begin @(negedge clk); #1; n++; end
    @(negedge clk); #1;
    bus0.req_addr = 7'h22; bus0.req_wdata = 8'h33;
    n = 0;
    while (bus0.req_ready !== 1'b1 && n < 1000) begin @(negedge clk); #1; n++; end
    checks++;
    if (n < 175 || n >= 1000) begin failures++; $display("FAIL b2b_second_accept_delay got=%0d exp=175..999", n); end
    checks++; if (last_mosi0 !== 16'h2111) begin failures++; $display("FAIL b2b_first_mosi got=%h exp=2111", last_mosi0); end
    @(negedge clk); #1;
    bus0.req_valid = 1'b0;
    wait_rsp0(got, d);
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL b2b_second_rsp got=%b exp=1", got); end
    checks++; if (last_mosi0 !== 16'h2233) begin failures++; $display("FAIL b2b_second_mosi got=%h exp=2233", last_mosi0); end
    checks++; if (last_gap0 < 10) begin failures++; $display("FAIL b2b_cs_gap got=%0d exp>=10", last_gap0); end
    checks++; if (rsp_cnt0 - c0 != 2) begin failures++; $display("FAIL b2b_rsp_count got=%0d exp=2", rsp_cnt0 - c0); end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_midframe_reset();
    logic got; logic [7:0] d; int c0; int n;
    c0 = rsp_cnt0;
    send0(1'b0, 7'h34, 8'h56);
    n = 0;
    while (rises0 < 7 && n < 1000) begin @(negedge clk); #1; n++; end
    checks++; if (rises0 != 7) begin failures++; $display("FAIL midreset_reach_rise7 got=%0d exp=7", rises0); end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({cs0, sck0, sdo0} !== 3'b100) begin failures++; $display("FAIL midreset_pins got=%b exp=100", {cs0, sck0, sdo0}); end
    checks++;
    if ({bus0.rsp_valid, bus0.busy, bus0.req_ready} !== 3'b000) begin
      failures++; $display("FAIL midreset_status got=%b exp=000", {bus0.rsp_valid, bus0.busy, bus0.req_ready});
    end
    rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    checks++; if (rsp_cnt0 != c0) begin failures++; $display("FAIL midreset_no_rsp got=%0d exp=0", rsp_cnt0 - c0); end
    send0(1'b0, 7'h00, 8'hFF);
    wait_rsp0(got, d);
    checks++; if (got !== 1'b1 || d !== 8'h00) begin failures++; $display("FAIL midreset_next_rsp got=%b/%h exp=1/00", got, d); end
    checks++; if (last_mosi0 !== 16'h00FF) begin failures++; $display("FAIL midreset_next_mosi got=%h exp=00ff", last_mosi0); end
    checks++; if (last_low0 != 165) begin failures++; $display("FAIL midreset_next_cs_low got=%0d exp=165", last_low0); end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_ignore_midframe();
    logic got; int c0; logic ready_seen;
    c0 = rsp_cnt0;
    send0(1'b0, 7'h40, 8'h0F);
    ready_seen = 1'b0; got = 1'b0;
    bus0.req_valid = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      bus0.req_addr = ~bus0.req_addr; bus0.req_wdata = ~bus0.req_wdata;
      @(negedge clk); #1;
      if (bus0.rsp_valid === 1'b1) got = 1'b1;
      else if (bus0.req_ready !== 1'b0) ready_seen = 1'b1;
    end
    bus0.req_valid = 1'b0;
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL ignore_rsp got=%b exp=1", got); end
    checks++; if (ready_seen !== 1'b0) begin failures++; $display("FAIL ignore_ready_low got=%b exp=0", ready_seen); end
    checks++; if (last_mosi0 !== 16'h400F) begin failures++; $display("FAIL ignore_mosi got=%h exp=400f", last_mosi0); end
    repeat (40) @(negedge clk);
    #1;
    checks++;
    if (rsp_cnt0 - c0 != 1 || cs0 !== 1'b1) begin
      failures++; $display("FAIL ignore_not_queued rsp=%0d cs=%b exp=1/1", rsp_cnt0 - c0, cs0);
    end
  endtask

  task automatic test_halfdiv2();
    logic got; logic [7:0] d; int n;
    @(negedge clk); #1;
    bus1.req_rd = 1'b0; bus1.req_addr = 7'h5F; bus1.req_wdata = 8'h01; bus1.req_valid = 1'b1;
    n = 0;
    while (bus1.req_ready !== 1'b1 && n < 1000) begin @(negedge clk); #1; n++; end
    @(negedge clk); #1;
    bus1.req_valid = 1'b0;
    got = 1'b0; d = '0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk); #1;
      if (bus1.rsp_valid === 1'b1) begin got = 1'b1; d = bus1.rsp_rdata; end
    end
    checks++; if (got !== 1'b1 || d !== 8'h00) begin failures++; $display("FAIL hd2_rsp got=%b/%h exp=1/00", got, d); end
    checks++; if (last_low1 != 66) begin failures++; $display("FAIL hd2_cs_low got=%0d exp=66", last_low1); end
    checks++; if (last_mosi1 !== 16'h5F01) begin failures++; $display("FAIL hd2_mosi got=%h exp=5f01", last_mosi1); end
    checks++;
    if (last_pmin1 != 4 || last_pmax1 != 4) begin
      failures++; $display("FAIL hd2_sck_period got=%0d..%0d exp=4", last_pmin1, last_pmax1);
    end
    checks++; if (last_rises1 != 16) begin failures++; $display("FAIL hd2_sck_rises got=%0d exp=16", last_rises1); end
  endtask

  initial begin
    bus0.req_valid = 1'b0; bus0.req_rd = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus1.req_valid = 1'b0; bus1.req_rd = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_midframe_reset();
    test_ignore_midframe();
    test_halfdiv2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
